// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ready fetches to
// instruction memory, buffers one fetched word and presents it (with its
// address and PC+4) to the IF/ID register. Branch redirects override
// everything except reset and raise a same-cycle IF/ID flush.
// Optional feature macro: IF_BYPASS_EN (zero-wait memory words pass straight
// to instr_o when IF/ID accepts in the same cycle, sustaining 1 instr/cycle).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] address_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_add4_o,
    output logic        valid_o,
    output logic        flush_o
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_addr_p1;
    logic [31:0] buf_instr_p1;
    logic        capture;

    // Sequential PC increment; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    // Next-state / PC selection and all output decoding; redirect beats
    // pc_write and any same-cycle memory data.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        capture     = 1'b0;
        imem_req_o  = 1'b0;
        imem_addr_o = 32'h0;
        valid_o     = 1'b0;
        address_o   = 32'h0;
        instr_o     = 32'h0;
        pc_add4_o   = 32'h0;
        flush_o     = 1'b0;
        if (!rst_i) begin
            flush_o     = branch_taken_i;
            imem_addr_o = pc_q;
            case (state_q)
                FETCH: begin
                    imem_req_o = 1'b1;
                    if (branch_taken_i) begin
                        pc_d = align_word(branch_target_i);
                    end else if (imem_ready_i) begin
`ifdef IF_BYPASS_EN
                        if (pc_write_i) begin
                            valid_o   = 1'b1;
                            address_o = pc_q;
                            instr_o   = imem_rdata_i;
                            pc_add4_o = pc_plus4(pc_q);
                            pc_d      = pc_plus4(pc_q);
                        end else begin
                            capture = 1'b1;
                            state_d = HOLD;
                        end
`else
                        capture = 1'b1;
                        state_d = HOLD;
`endif
                    end
                end
                HOLD: begin
                    valid_o   = 1'b1;
                    address_o = buf_addr_p1;
                    instr_o   = buf_instr_p1;
                    pc_add4_o = pc_plus4(buf_addr_p1);
                    if (branch_taken_i) begin
                        pc_d    = align_word(branch_target_i);
                        state_d = FETCH;
                    end else if (pc_write_i) begin
                        pc_d    = pc_plus4(pc_q);
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Control state: FSM and PC, reset to FETCH at RESET_PC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // ---- stage p1: fetched-word buffer (qualified by state HOLD) ----
    // Data-only registers; their validity is carried entirely by the FSM.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            buf_addr_p1  <= pc_q;
            buf_instr_p1 <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by a
// randomized run against a cycle-level behavioural model of the fetch rules.
module tb_if_fetch_stage;

`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, pcw, br, rdy;
    logic [31:0] tgt, rdata;
    logic        imem_req_o, valid_o, flush_o;
    logic [31:0] imem_addr_o, address_o, instr_o, pc_add4_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: PC, and whether a fetched word is waiting for IF/ID.
    logic [31:0] m_pc;
    bit          m_have;
    logic [31:0] m_addr, m_instr;

    // Expected outputs for the current inputs.
    logic        e_req, e_valid, e_flush;
    logic [31:0] e_iaddr, e_addr, e_instr, e_add4;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pc_write_i     (pcw),
        .branch_taken_i (br),
        .branch_target_i(tgt),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ready_i   (rdy),
        .imem_rdata_i   (rdata),
        .address_o      (address_o),
        .instr_o        (instr_o),
        .pc_add4_o      (pc_add4_o),
        .valid_o        (valid_o),
        .flush_o        (flush_o)
    );

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    // Apply inputs at the negedge; memory answers for whatever address is on the bus.
    task automatic drive(input logic r, input logic w, input logic b,
                         input logic [31:0] t, input logic rd);
        rst = r; pcw = w; br = b; tgt = t; rdy = rd;
        #1;
        rdata = rd ? mem_word(imem_addr_o) : $urandom;
        #1;
    endtask

    // Advance one clock and step the model with the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_pc = RST_PC; m_have = 0;
        end else if (br) begin
            m_pc = {tgt[31:2], 2'b00}; m_have = 0;
        end else if (m_have) begin
            if (pcw) begin
                m_pc = m_addr + 32'd4; m_have = 0;
            end
        end else if (rdy) begin
            if (BYP && pcw) m_pc = m_pc + 32'd4;
            else begin
                m_have = 1; m_addr = m_pc; m_instr = rdata;
            end
        end
        @(negedge clk);
    endtask

    // What the outputs must be right now, given model state and inputs.
    task automatic predict();
        e_req = 0; e_iaddr = 0; e_valid = 0; e_addr = 0; e_instr = 0; e_add4 = 0;
        e_flush = br && !rst;
        if (!rst) begin
            e_iaddr = m_pc;
            if (m_have) begin
                e_valid = 1; e_addr = m_addr; e_instr = m_instr; e_add4 = m_addr + 32'd4;
            end else begin
                e_req = 1;
                if (BYP && rdy && pcw && !br) begin
                    e_valid = 1; e_addr = m_pc; e_instr = rdata; e_add4 = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 32'h1234_5678, 1);
            n_checks++; if (imem_req_o !== 1'b0) $display("FAIL rst_req got=%b exp=0", imem_req_o); else n_pass++;
            n_checks++; if (valid_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", valid_o); else n_pass++;
            n_checks++; if (flush_o !== 1'b0) $display("FAIL rst_flush got=%b exp=0", flush_o); else n_pass++;
            n_checks++; if ({address_o, instr_o, pc_add4_o} !== 96'h0)
                $display("FAIL rst_data got=%h/%h/%h exp=0", address_o, instr_o, pc_add4_o); else n_pass++;
            tick();
        end
    endtask

    // Free-running fetch from RESET_PC with always-ready memory.
    task automatic test_sequence();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            a = RST_PC + 32'(4 * k);
            drive(0, 1, 0, 0, 1);
            n_checks++; if (imem_addr_o !== a || imem_req_o !== 1'b1)
                $display("FAIL seq_fetch k=%0d got=%h/%b exp=%h/1", k, imem_addr_o, imem_req_o, a); else n_pass++;
            if (BYP) begin
                n_checks++; if (valid_o !== 1'b1 || address_o !== a || instr_o !== mem_word(a))
                    $display("FAIL seq_bypass k=%0d got=%b/%h/%h exp=1/%h/%h", k, valid_o, address_o, instr_o, a, mem_word(a)); else n_pass++;
                tick();
            end else begin
                n_checks++; if (valid_o !== 1'b0) $display("FAIL seq_gap k=%0d got=%b exp=0", k, valid_o); else n_pass++;
                tick();
                drive(0, 1, 0, 0, 1);
                n_checks++; if (valid_o !== 1'b1 || address_o !== a || instr_o !== mem_word(a) || pc_add4_o !== a + 32'd4)
                    $display("FAIL seq_present k=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", k, valid_o, address_o, instr_o, pc_add4_o,
                             a, mem_word(a), a + 32'd4); else n_pass++;
                n_checks++; if (imem_req_o !== 1'b0) $display("FAIL seq_noreq k=%0d got=%b exp=0", k, imem_req_o); else n_pass++;
                tick();
            end
        end
    endtask

    // Memory wait states at address 12, then the word is buffered (pc_write low).
    task automatic test_wait();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0);
            n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd12 || valid_o !== 1'b0)
                $display("FAIL wait_hold i=%0d got=%b/%h/%b exp=1/0000000c/0", i, imem_req_o, imem_addr_o, valid_o); else n_pass++;
            tick();
        end
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        n_checks++; if (valid_o !== 1'b1 || address_o !== 32'd12 || instr_o !== mem_word(32'd12) || pc_add4_o !== 32'd16)
            $display("FAIL wait_data got=%b/%h/%h/%h exp=1/0000000c/%h/00000010", valid_o, address_o, instr_o, pc_add4_o,
                     mem_word(32'd12)); else n_pass++;
    endtask

    // Stall in HOLD for 5 cycles, then release.
    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1);
            n_checks++; if (imem_req_o !== 1'b0 || valid_o !== 1'b1 || address_o !== 32'd12 || instr_o !== mem_word(32'd12))
                $display("FAIL stall i=%0d got=%b/%b/%h/%h exp=0/1/0000000c/%h", i, imem_req_o, valid_o, address_o, instr_o,
                         mem_word(32'd12)); else n_pass++;
            tick();
        end
        drive(0, 1, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0);
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd16)
            $display("FAIL stall_release got=%b/%h exp=1/00000010", imem_req_o, imem_addr_o); else n_pass++;
    endtask

    // Redirect while memory returns data: data dropped, fetch at aligned target.
    task automatic test_redirect();
        drive(0, 1, 1, 32'h0000_0103, 1);
        n_checks++; if (flush_o !== 1'b1 || valid_o !== 1'b0)
            $display("FAIL redir_flush got=%b/%b exp=1/0", flush_o, valid_o); else n_pass++;
        tick();
        drive(0, 1, 0, 0, 0);
        n_checks++; if (imem_addr_o !== 32'h100 || imem_req_o !== 1'b1 || valid_o !== 1'b0 || flush_o !== 1'b0)
            $display("FAIL redir_target got=%h/%b/%b/%b exp=00000100/1/0/0", imem_addr_o, imem_req_o, valid_o, flush_o); else n_pass++;
    endtask

    // Redirect during a HOLD stall wins over the stall.
    task automatic test_redirect_stall();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 1, 32'h0000_0200, 0);
        n_checks++; if (flush_o !== 1'b1) $display("FAIL rstall_flush got=%b exp=1", flush_o); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200 || valid_o !== 1'b0 || instr_o !== 32'h0)
            $display("FAIL rstall_fetch got=%b/%h/%b/%h exp=1/00000200/0/0", imem_req_o, imem_addr_o, valid_o, instr_o); else n_pass++;
    endtask

    // PC wrap at the top of the address space, then reset mid-wait.
    task automatic test_wrap_and_reset();
        drive(0, 0, 1, 32'hFFFF_FFFF, 0);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (address_o !== 32'hFFFF_FFFC || pc_add4_o !== 32'h0 || valid_o !== 1'b1)
            $display("FAIL wrap_add4 got=%h/%h/%b exp=fffffffc/00000000/1", address_o, pc_add4_o, valid_o); else n_pass++;
        drive(0, 1, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0);
        n_checks++; if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1)
            $display("FAIL wrap_fetch got=%h/%b exp=00000000/1", imem_addr_o, imem_req_o); else n_pass++;
        drive(0, 1, 1, 32'h0000_0040, 0);
        tick();
        drive(0, 1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 1);
        n_checks++; if ({imem_req_o, valid_o, flush_o} !== 3'b000 || {imem_addr_o, address_o, instr_o, pc_add4_o} !== 128'h0)
            $display("FAIL midwait_rst got=%b%b%b/%h/%h/%h/%h exp=000/0", imem_req_o, valid_o, flush_o, imem_addr_o, address_o,
                     instr_o, pc_add4_o); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (imem_addr_o !== RST_PC || imem_req_o !== 1'b1 || valid_o !== 1'b0)
            $display("FAIL post_rst got=%h/%b/%b exp=%h/1/0", imem_addr_o, imem_req_o, valid_o, RST_PC); else n_pass++;
    endtask

    // Randomized inputs against the model.
    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, t,
                  $urandom_range(0, 1) == 1);
            predict();
            n_checks++;
            if (imem_req_o !== e_req || imem_addr_o !== e_iaddr || valid_o !== e_valid || flush_o !== e_flush ||
                address_o !== e_addr || instr_o !== e_instr || pc_add4_o !== e_add4)
                $display("FAIL rand c=%0d got req=%b ia=%h v=%b f=%b a=%h i=%h p4=%h exp req=%b ia=%h v=%b f=%b a=%h i=%h p4=%h",
                         c, imem_req_o, imem_addr_o, valid_o, flush_o, address_o, instr_o, pc_add4_o,
                         e_req, e_iaddr, e_valid, e_flush, e_addr, e_instr, e_add4);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst = 1; pcw = 0; br = 0; tgt = 0; rdy = 0; rdata = 0;
        m_pc = RST_PC; m_have = 0; m_addr = 0; m_instr = 0;
        @(negedge clk);
        test_reset();
        test_sequence();
        test_wait();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
